medida_dht11: RTL

//  Upstream stage of transmissao_medida: runs one DHT11 single-wire read on request and

---
 rtl/medida_dht11_pkg.sv | 43 ++++
 rtl/gerador_tick_us.sv | 32 +++
 rtl/medida_dht11_fd.sv | 127 ++++++++++++
 rtl/medida_dht11_uc.sv | 116 +++++++++++
 rtl/medida_dht11.sv | 79 +++++++
 5 files changed

// File: rtl/medida_dht11_pkg.sv
// Shared definitions for the DHT11 read block: FSM state encoding, layout of the
// 40-bit sensor frame, default timing constants and the frame checksum helper.
package medida_dht11_pkg;

  // FSM states of the control unit
  typedef enum logic [3:0] {
    Espera,
    StartLow,
    Libera,
    RespLow,
    RespHigh,
    BitLow,
    BitHigh,
    Verifica,
    Pronto,
    Erro
  } estado_t;

  // Default timing (50 MHz clock)
  localparam int unsigned CICLOS_US_PADRAO     = 50;
  localparam int unsigned START_LOW_US_PADRAO  = 18000;
  localparam int unsigned TIMEOUT_US_PADRAO    = 200;
  localparam int unsigned LIMIAR_BIT_US_PADRAO = 50;

  // Frame layout, MSB first on the wire:
  // {hum int, hum dec, temp int, temp dec, checksum}
  localparam int unsigned NUM_BITS     = 40;
  localparam int unsigned BIT_CONT_W   = 6;
  localparam int unsigned HUM_INT_LSB  = 32;
  localparam int unsigned HUM_DEC_LSB  = 24;
  localparam int unsigned TEMP_INT_LSB = 16;
  localparam int unsigned TEMP_DEC_LSB = 8;
  localparam int unsigned SOMA_LSB     = 0;

  // 8-bit wrapping sum of the four data bytes must equal the checksum byte
  function automatic logic soma_confere(input logic [NUM_BITS-1:0] d);
    logic [7:0] soma;
    soma = d[HUM_INT_LSB +: 8] + d[HUM_DEC_LSB +: 8] + d[TEMP_INT_LSB +: 8]
         + d[TEMP_DEC_LSB +: 8];
    return soma == d[SOMA_LSB +: 8];
  endfunction

endpackage

// File: rtl/gerador_tick_us.sv
// Microsecond tick generator.
// Ports:
//   clock  system clock
//   reset  asynchronous, active-high
//   limpa  restarts the count so the next tick lands exactly CICLOS_US cycles later
//   tick   one-cycle pulse every CICLOS_US cycles
module gerador_tick_us #(
  parameter int unsigned CICLOS_US = 50
) (
  input  logic clock,
  input  logic reset,
  input  logic limpa,
  output logic tick
);

  localparam int unsigned LARG = (CICLOS_US > 1) ? $clog2(CICLOS_US) : 1;

  logic [LARG-1:0] cont_q;

  assign tick = (cont_q == LARG'(CICLOS_US - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cont_q <= '0;
    end else if (limpa || tick) begin
      cont_q <= '0;
    end else begin
      cont_q <= cont_q + LARG'(1);
    end
  end

endmodule

// File: rtl/medida_dht11_fd.sv
// Datapath of the DHT11 read: input synchroniser and edge detect, us tick, phase
// timer, 40-bit shift register with bit counter, checksum and output registers.
// Ports:
//   clock, reset              system clock, asynchronous active-high reset
//   dht_in                    raw bus line (asynchronous)
//   limpa_fase                clear phase timer and tick divider (state entry)
//   limpa_dados               clear shift register and bit counter (new read)
//   desloca                   shift in one bit measured from the current high phase
//   carrega                   load temperatura/umidade from the received frame
//   sobe, desce               rising / falling edge of the synchronised line
//   fim_start                 start pulse has lasted START_LOW_US
//   estouro                   current phase has lasted TIMEOUT_US
//   ultimo_bit                the bit being shifted now is the 40th
//   soma_ok                   checksum of the received frame matches
//   temperatura, umidade      last valid measurement
module medida_dht11_fd
  import medida_dht11_pkg::*;
#(
  parameter int unsigned CICLOS_US     = CICLOS_US_PADRAO,
  parameter int unsigned START_LOW_US  = START_LOW_US_PADRAO,
  parameter int unsigned TIMEOUT_US    = TIMEOUT_US_PADRAO,
  parameter int unsigned LIMIAR_BIT_US = LIMIAR_BIT_US_PADRAO
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dht_in,
  input  logic        limpa_fase,
  input  logic        limpa_dados,
  input  logic        desloca,
  input  logic        carrega,
  output logic        sobe,
  output logic        desce,
  output logic        fim_start,
  output logic        estouro,
  output logic        ultimo_bit,
  output logic        soma_ok,
  output logic [15:0] temperatura,
  output logic [15:0] umidade
);

  localparam int unsigned MAIOR_AB = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
  localparam int unsigned MAIOR_US = (MAIOR_AB > LIMIAR_BIT_US) ? MAIOR_AB : LIMIAR_BIT_US;
  localparam int unsigned TIMER_W  = $clog2(MAIOR_US + 1);

  logic                  sinc1_q, sinc2_q, ant_q;
  logic                  tick;
  logic [TIMER_W-1:0]    timer_q;
  logic                  bit_val;
  logic [NUM_BITS-1:0]   dados_q;
  logic [BIT_CONT_W-1:0] bit_cont_q;
  logic [15:0]           temp_q, umid_q;

  // Two-flop synchroniser plus one delayed copy for edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sinc1_q <= 1'b0;
      sinc2_q <= 1'b0;
      ant_q   <= 1'b0;
    end else begin
      sinc1_q <= dht_in;
      sinc2_q <= sinc1_q;
      ant_q   <= sinc2_q;
    end
  end

  assign sobe  = sinc2_q & ~ant_q;
  assign desce = ~sinc2_q & ant_q;

  // Divider restarts with the timer so phase lengths are exact multiples of 1 us
  gerador_tick_us #(
    .CICLOS_US(CICLOS_US)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .limpa(limpa_fase),
    .tick (tick)
  );

  // Phase timer in us; free-running (wrapping) in Espera is harmless
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else if (limpa_fase) begin
      timer_q <= '0;
    end else if (tick) begin
      timer_q <= timer_q + TIMER_W'(1);
    end
  end

  // Fire on the tick that completes the last us of the phase
  assign fim_start = tick && (timer_q == TIMER_W'(START_LOW_US - 1));
  assign estouro   = tick && (timer_q == TIMER_W'(TIMEOUT_US - 1));

  // Bit value from the width of the high phase that is ending now
  assign bit_val = (timer_q > TIMER_W'(LIMIAR_BIT_US));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dados_q    <= '0;
      bit_cont_q <= '0;
    end else if (limpa_dados) begin
      dados_q    <= '0;
      bit_cont_q <= '0;
    end else if (desloca) begin
      dados_q    <= {dados_q[NUM_BITS-2:0], bit_val};
      bit_cont_q <= bit_cont_q + BIT_CONT_W'(1);
    end
  end

  assign ultimo_bit = (bit_cont_q == BIT_CONT_W'(NUM_BITS - 1));
  assign soma_ok    = soma_confere(dados_q);

  // Loaded on the Verifica->Pronto edge so new values appear with the pronto pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      temp_q <= '0;
      umid_q <= '0;
    end else if (carrega) begin
      umid_q <= dados_q[HUM_DEC_LSB +: 16];
      temp_q <= dados_q[TEMP_DEC_LSB +: 16];
    end
  end

  assign temperatura = temp_q;
  assign umidade     = umid_q;

endmodule

// File: rtl/medida_dht11_uc.sv
// Control unit of the DHT11 read: sequences start pulse, sensor response, 40 data
// bits, checksum verification and the pronto/erro strobes.
// Ports:
//   clock, reset                 system clock, asynchronous active-high reset
//   medir                        start request (only honoured in Espera)
//   sobe, desce                  edges of the synchronised bus line
//   fim_start, estouro           timing conditions from the datapath
//   ultimo_bit, soma_ok          frame status from the datapath
//   limpa_fase                   state is changing: restart phase timer
//   limpa_dados                  new read: clear shift register
//   desloca, carrega             shift a bit / load outputs
//   dht_drive_low                pull the bus low
//   ocupado, pronto, erro        status outputs
module medida_dht11_uc
  import medida_dht11_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic medir,
  input  logic sobe,
  input  logic desce,
  input  logic fim_start,
  input  logic estouro,
  input  logic ultimo_bit,
  input  logic soma_ok,
  output logic limpa_fase,
  output logic limpa_dados,
  output logic desloca,
  output logic carrega,
  output logic dht_drive_low,
  output logic ocupado,
  output logic pronto,
  output logic erro
);

  estado_t estado_q, estado_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= Espera;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d      = estado_q;
    limpa_dados   = 1'b0;
    desloca       = 1'b0;
    carrega       = 1'b0;
    dht_drive_low = 1'b0;
    pronto        = 1'b0;
    erro          = 1'b0;

    unique case (estado_q)
      Espera: begin
        if (medir) begin
          estado_d    = StartLow;
          limpa_dados = 1'b1;
        end
      end
      StartLow: begin
        dht_drive_low = 1'b1;
        if (fim_start) estado_d = Libera;
      end
      // The synchronised line still shows our own start pulse for a few cycles
      // after release, so wait for it to go low afresh (a falling edge).
      Libera: begin
        if (desce)        estado_d = RespLow;
        else if (estouro) estado_d = Erro;
      end
      RespLow: begin
        if (sobe)         estado_d = RespHigh;
        else if (estouro) estado_d = Erro;
      end
      RespHigh: begin
        if (desce)        estado_d = BitLow;
        else if (estouro) estado_d = Erro;
      end
      BitLow: begin
        if (sobe)         estado_d = BitHigh;
        else if (estouro) estado_d = Erro;
      end
      BitHigh: begin
        // A completed bit wins over a timeout landing in the same cycle
        if (desce) begin
          desloca  = 1'b1;
          estado_d = ultimo_bit ? Verifica : BitLow;
        end else if (estouro) begin
          estado_d = Erro;
        end
      end
      Verifica: begin
        if (soma_ok) begin
          carrega  = 1'b1;
          estado_d = Pronto;
        end else begin
          estado_d = Erro;
        end
      end
      Pronto: begin
        pronto   = 1'b1;
        estado_d = Espera;
      end
      Erro: begin
        erro     = 1'b1;
        estado_d = Espera;
      end
      default: estado_d = Espera;
    endcase

    ocupado    = (estado_q != Espera);
    limpa_fase = (estado_d != estado_q);
  end

endmodule

// File: rtl/medida_dht11.sv
// DHT11 single-wire read on request. Returns {int, dec} temperatura/umidade words,
// a one-cycle pronto strobe for a valid read and a one-cycle erro strobe for a
// timeout or checksum failure (previous measurement kept).
// Ports:
//   clock, reset     system clock, asynchronous active-high reset
//   medir            start request, sampled only while idle
//   dht_in           bus line as seen by the FPGA (asynchronous)
//   dht_drive_low    1 = pull bus low through the open-drain buffer, 0 = release
//   temperatura      {temp int, temp dec} of the last valid read
//   umidade          {hum int, hum dec} of the last valid read
//   ocupado          1 while a read is in progress
//   pronto, erro     one-cycle result strobes
module medida_dht11
  import medida_dht11_pkg::*;
#(
  parameter int unsigned CICLOS_US     = CICLOS_US_PADRAO,
  parameter int unsigned START_LOW_US  = START_LOW_US_PADRAO,
  parameter int unsigned TIMEOUT_US    = TIMEOUT_US_PADRAO,
  parameter int unsigned LIMIAR_BIT_US = LIMIAR_BIT_US_PADRAO
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        dht_in,
  output logic        dht_drive_low,
  output logic [15:0] temperatura,
  output logic [15:0] umidade,
  output logic        ocupado,
  output logic        pronto,
  output logic        erro
);

  logic sobe, desce, fim_start, estouro, ultimo_bit, soma_ok;
  logic limpa_fase, limpa_dados, desloca, carrega;

  medida_dht11_fd #(
    .CICLOS_US    (CICLOS_US),
    .START_LOW_US (START_LOW_US),
    .TIMEOUT_US   (TIMEOUT_US),
    .LIMIAR_BIT_US(LIMIAR_BIT_US)
  ) u_fd (
    .clock      (clock),
    .reset      (reset),
    .dht_in     (dht_in),
    .limpa_fase (limpa_fase),
    .limpa_dados(limpa_dados),
    .desloca    (desloca),
    .carrega    (carrega),
    .sobe       (sobe),
    .desce      (desce),
    .fim_start  (fim_start),
    .estouro    (estouro),
    .ultimo_bit (ultimo_bit),
    .soma_ok    (soma_ok),
    .temperatura(temperatura),
    .umidade    (umidade)
  );

  medida_dht11_uc u_uc (
    .clock        (clock),
    .reset        (reset),
    .medir        (medir),
    .sobe         (sobe),
    .desce        (desce),
    .fim_start    (fim_start),
    .estouro      (estouro),
    .ultimo_bit   (ultimo_bit),
    .soma_ok      (soma_ok),
    .limpa_fase   (limpa_fase),
    .limpa_dados  (limpa_dados),
    .desloca      (desloca),
    .carrega      (carrega),
    .dht_drive_low(dht_drive_low),
    .ocupado      (ocupado),
    .pronto       (pronto),
    .erro         (erro)
  );

endmodule
